// File: rtl/umi_host_agent.sv
// Single-outstanding UMI host agent: turns command-port reads/writes into UMI
// requests and returns the consistency-checked response on the result port.
module umi_host_agent #(
    parameter int              DW      = 256,
    parameter int              AW      = 64,
    parameter int              CW      = 32,
    parameter logic [AW-1:0]   SRCADDR = 64'h0,
    parameter int              TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_size,
    input  logic [7:0]    cmd_len,
    input  logic [DW-1:0] cmd_data,
    output logic          uhost_req_valid,
    input  logic          uhost_req_ready,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_resp_valid,
    output logic          uhost_resp_ready,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [15:0]   stray_cnt
);

    localparam logic [4:0]  OP_REQ_READ   = 5'h01;
    localparam logic [4:0]  OP_REQ_WRITE  = 5'h03;
    localparam logic [4:0]  OP_RESP_READ  = 5'h02;
    localparam logic [4:0]  OP_RESP_WRITE = 5'h04;
    localparam bit          TMO_EN        = (TIMEOUT > 0);
    localparam logic [31:0] TMO_LAST      = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [CW-1:0] req_cmd_word(input logic write,
                                                   input logic [2:0] size,
                                                   input logic [7:0] len);
        logic [CW-1:0] w;
        w       = {CW{1'b0}};
        w[4:0]  = write ? OP_REQ_WRITE : OP_REQ_READ;
        w[7:5]  = size;
        w[15:8] = len;
        w[22]   = 1'b1;
        w[23]   = 1'b1;
        return w;
    endfunction

    function automatic logic resp_bad(input logic          write,
                                      input logic [4:0]    op,
                                      input logic [AW-1:0] dst,
                                      input logic [AW-1:0] src,
                                      input logic [AW-1:0] req_dst);
        logic [4:0] exp_op;
        exp_op = write ? OP_RESP_WRITE : OP_RESP_READ;
        return (op != exp_op) || (dst != SRCADDR) || (src != req_dst);
    endfunction

    state_t        state_r, state_nxt_s;
    logic          cmd_ready_r, req_valid_r, resp_ready_r, rsp_valid_r;
    logic          cmd_ready_nxt_s, req_valid_nxt_s, resp_ready_nxt_s, rsp_valid_nxt_s;
    logic          write_r;
    logic [CW-1:0] req_cmd_r;
    logic [AW-1:0] req_dstaddr_r;
    logic [DW-1:0] req_data_r;
    logic [DW-1:0] rsp_data_r;
    logic          rsp_err_r;
    logic [15:0]   stray_cnt_r;
    logic [31:0]   tmo_cnt_r;
    logic          accept_s, resp_hs_s, capture_s, stray_s, tmo_hit_s;
    logic          unused_s;

    assign accept_s  = cmd_valid && cmd_ready_r;
    assign resp_hs_s = uhost_resp_valid && resp_ready_r;
    assign capture_s = resp_hs_s && (state_r == ST_WAIT);
    assign stray_s   = resp_hs_s && (state_r != ST_WAIT);
    assign tmo_hit_s = TMO_EN && (state_r == ST_WAIT) && (tmo_cnt_r == TMO_LAST);
    assign unused_s  = ^uhost_resp_cmd[CW-1:5];

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a response in the expiry cycle takes priority over the timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_REQ;
                else          state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (req_valid_r && uhost_req_ready) state_nxt_s = ST_WAIT;
                else                                state_nxt_s = ST_REQ;
            end
            ST_WAIT: begin
                if (resp_hs_s)      state_nxt_s = ST_DONE;
                else if (tmo_hit_s) state_nxt_s = ST_DONE;
                else                state_nxt_s = ST_WAIT;
            end
            ST_DONE: begin
                if (rsp_valid_r && rsp_ready) state_nxt_s = ST_IDLE;
                else                          state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        cmd_ready_nxt_s  = 1'b0;
        req_valid_nxt_s  = 1'b0;
        resp_ready_nxt_s = 1'b0;
        rsp_valid_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                cmd_ready_nxt_s  = 1'b1;
                resp_ready_nxt_s = 1'b1;
            end
            ST_REQ: begin
                req_valid_nxt_s  = 1'b1;
                resp_ready_nxt_s = 1'b1;
            end
            ST_WAIT: resp_ready_nxt_s = 1'b1;
            ST_DONE: rsp_valid_nxt_s  = 1'b1;
            default: begin
                cmd_ready_nxt_s  = 1'b0;
                resp_ready_nxt_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cmd_ready_r  <= 1'b0;
            req_valid_r  <= 1'b0;
            resp_ready_r <= 1'b0;
            rsp_valid_r  <= 1'b0;
        end else begin
            cmd_ready_r  <= cmd_ready_nxt_s;
            req_valid_r  <= req_valid_nxt_s;
            resp_ready_r <= resp_ready_nxt_s;
            rsp_valid_r  <= rsp_valid_nxt_s;
        end
    end

    // Request capture; fields stay frozen until the next accepted command
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            write_r       <= 1'b0;
            req_cmd_r     <= {CW{1'b0}};
            req_dstaddr_r <= {AW{1'b0}};
            req_data_r    <= {DW{1'b0}};
        end else if (accept_s) begin
            write_r       <= cmd_write;
            req_cmd_r     <= req_cmd_word(cmd_write, cmd_size, cmd_len);
            req_dstaddr_r <= cmd_addr;
            req_data_r    <= cmd_write ? cmd_data : {DW{1'b0}};
        end
    end

    // Result capture from a checked response or from timeout expiry
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rsp_data_r <= {DW{1'b0}};
            rsp_err_r  <= 1'b0;
        end else if (capture_s) begin
            rsp_err_r  <= resp_bad(write_r, uhost_resp_cmd[4:0], uhost_resp_dstaddr,
                                   uhost_resp_srcaddr, req_dstaddr_r);
            rsp_data_r <= write_r ? {DW{1'b0}} : uhost_resp_data;
        end else if (tmo_hit_s) begin
            rsp_err_r  <= 1'b1;
            rsp_data_r <= {DW{1'b0}};
        end
    end

    // Timeout counter: held at zero in REQ so WAIT always starts from zero
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tmo_cnt_r <= 32'd0;
        end else if (state_r == ST_REQ) begin
            tmo_cnt_r <= 32'd0;
        end else if (TMO_EN && (state_r == ST_WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
    end

    // Saturating count of dropped out-of-window responses
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stray_cnt_r <= 16'd0;
        end else if (stray_s && (stray_cnt_r != 16'hFFFF)) begin
            stray_cnt_r <= stray_cnt_r + 16'd1;
        end
    end

    assign cmd_ready         = cmd_ready_r;
    assign uhost_req_valid   = req_valid_r;
    assign uhost_req_cmd     = req_cmd_r;
    assign uhost_req_dstaddr = req_dstaddr_r;
    assign uhost_req_srcaddr = SRCADDR;
    assign uhost_req_data    = req_data_r;
    assign uhost_resp_ready  = resp_ready_r;
    assign rsp_valid         = rsp_valid_r;
    assign rsp_data          = rsp_data_r;
    assign rsp_err           = rsp_err_r;
    assign stray_cnt         = stray_cnt_r;

endmodule

// File: tb/tb_umi_host_agent.sv
// Table-driven bench for umi_host_agent with a small RAM-style device model
// and a result scoreboard.
module tb_umi_host_agent;

    localparam int          DW  = 256;
    localparam int          AW  = 64;
    localparam int          CW  = 32;
    localparam logic [63:0] SRC = 64'h0000_00AB_0000_0000;
    localparam int          TMO = 8;

    logic          clk = 1'b0;
    logic          nreset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_size;
    logic [7:0]    cmd_len;
    logic [DW-1:0] cmd_data;
    logic          uhost_req_valid, uhost_req_ready;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_resp_valid, uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [15:0]   stray_cnt;

    umi_host_agent #(.DW(DW), .AW(AW), .CW(CW), .SRCADDR(SRC), .TIMEOUT(TMO)) dut (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .uhost_req_valid(uhost_req_valid), .uhost_req_ready(uhost_req_ready),
        .uhost_req_cmd(uhost_req_cmd), .uhost_req_dstaddr(uhost_req_dstaddr),
        .uhost_req_srcaddr(uhost_req_srcaddr), .uhost_req_data(uhost_req_data),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_ready(uhost_resp_ready),
        .uhost_resp_cmd(uhost_resp_cmd), .uhost_resp_dstaddr(uhost_resp_dstaddr),
        .uhost_resp_srcaddr(uhost_resp_srcaddr), .uhost_resp_data(uhost_resp_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         write;
        logic [63:0]  addr;
        logic [2:0]   size;
        logic [7:0]   len;
        logic [255:0] data;
        logic [4:0]   resp_op;
        logic         bad_dst;
        logic         bad_src;
        logic         silent;
        logic         abort;
        int           req_stall;
        int           rsp_stall;
        logic [31:0]  exp_cmd;
        logic         exp_err;
        logic [255:0] exp_data;
    } vec_t;

    typedef struct {
        logic [255:0] data;
        logic         err;
    } exp_t;

    vec_t         vecs [11];
    exp_t         exp_q [$];
    exp_t         sb_e;
    logic [255:0] ram [logic [63:0]];
    int           checks   = 0;
    int           failures = 0;

    function automatic vec_t mk(input logic w, input logic [63:0] a, input logic [2:0] s,
                                input logic [7:0] l, input logic [255:0] d, input logic [4:0] op,
                                input logic bd, input logic bs, input logic sil, input logic ab,
                                input int rqs, input int rss, input logic [31:0] ec,
                                input logic ee, input logic [255:0] ed);
        vec_t v;
        v.write = w; v.addr = a; v.size = s; v.len = l; v.data = d; v.resp_op = op;
        v.bad_dst = bd; v.bad_src = bs; v.silent = sil; v.abort = ab;
        v.req_stall = rqs; v.rsp_stall = rss; v.exp_cmd = ec; v.exp_err = ee; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each result at its handshake against the queued expectation
    always @(negedge clk) begin
        if (nreset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rsp", 256'd1, 256'd0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("rsp_data", rsp_data, sb_e.data);
                chk("rsp_err", {255'd0, rsp_err}, {255'd0, sb_e.err});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {255'd0, cmd_ready}, 256'd0);
        chk({tag, "_req_valid"}, {255'd0, uhost_req_valid}, 256'd0);
        chk({tag, "_resp_ready"}, {255'd0, uhost_resp_ready}, 256'd0);
        chk({tag, "_rsp_valid"}, {255'd0, rsp_valid}, 256'd0);
        chk({tag, "_rsp_data"}, rsp_data, 256'd0);
        chk({tag, "_rsp_err"}, {255'd0, rsp_err}, 256'd0);
        chk({tag, "_stray_cnt"}, {240'd0, stray_cnt}, 256'd0);
        chk({tag, "_req_cmd"}, {224'd0, uhost_req_cmd}, 256'd0);
        chk({tag, "_req_dstaddr"}, {192'd0, uhost_req_dstaddr}, 256'd0);
        chk({tag, "_req_data"}, uhost_req_data, 256'd0);
    endtask

    task automatic run_txn(input vec_t v);
        int           n;
        logic [255:0] held;
        logic [255:0] exp_req_data;
        exp_req_data = v.write ? v.data : 256'd0;
        tick();
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_size = v.size; cmd_len = v.len; cmd_data = v.data;
        if (!v.abort) exp_q.push_back('{v.exp_data, v.exp_err});
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("cmd_ready_wait", {255'd0, n < 50}, 256'd1);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i <= v.req_stall; i++) begin
            chk("req_valid", {255'd0, uhost_req_valid}, 256'd1);
            chk("req_cmd", {224'd0, uhost_req_cmd}, {224'd0, v.exp_cmd});
            chk("req_dstaddr", {192'd0, uhost_req_dstaddr}, {192'd0, v.addr});
            chk("req_data", uhost_req_data, exp_req_data);
            chk("cmd_ready_busy", {255'd0, cmd_ready}, 256'd0);
            if (i < v.req_stall) tick();
        end
        chk("req_srcaddr", {192'd0, uhost_req_srcaddr}, {192'd0, SRC});
        uhost_req_ready = 1'b1;
        tick();
        uhost_req_ready = 1'b0;
        chk("req_valid_after_hs", {255'd0, uhost_req_valid}, 256'd0);
        if (v.abort) begin
            tick(); tick();
            nreset = 1'b0;
            #1;
            check_reset_outputs("abort");
            tick();
            nreset = 1'b1;
            tick();
            return;
        end
        if (!v.silent) begin
            uhost_resp_valid   = 1'b1;
            uhost_resp_cmd     = {27'd0, v.resp_op};
            uhost_resp_dstaddr = v.bad_dst ? (SRC ^ 64'h1) : SRC;
            uhost_resp_srcaddr = v.bad_src ? (v.addr ^ 64'h8) : v.addr;
            if (v.write) begin
                ram[v.addr]     = v.data;
                uhost_resp_data = {8{32'hBAD0_BAD0}};
            end else begin
                uhost_resp_data = ram.exists(v.addr) ? ram[v.addr] : 256'd0;
            end
            tick();
            uhost_resp_valid = 1'b0;
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin tick(); n++; end
        chk("rsp_latency", n, v.silent ? TMO : 0);
        chk("resp_ready_done", {255'd0, uhost_resp_ready}, 256'd0);
        held = rsp_data;
        for (int i = 0; i < v.rsp_stall; i++) begin
            tick();
            chk("rsp_hold_valid", {255'd0, rsp_valid}, 256'd1);
            chk("rsp_hold_data", rsp_data, held);
            chk("cmd_ready_done", {255'd0, cmd_ready}, 256'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", {255'd0, rsp_valid}, 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1'b1, 64'h100, 3'd3, 8'd0, 256'hDEADBEEF, 5'h04, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00C00063, 1'b0, 256'd0);
        vecs[1]  = mk(1'b0, 64'h100, 3'd3, 8'd0, 256'hFFFF,     5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00C00061, 1'b0, 256'hDEADBEEF);
        vecs[2]  = mk(1'b1, 64'h200, 3'd2, 8'd1, 256'h12345678, 5'h04, 1'b0, 1'b0, 1'b0, 1'b0, 5, 4, 32'h00C00143, 1'b0, 256'd0);
        vecs[3]  = mk(1'b0, 64'h200, 3'd2, 8'd1, 256'd0,        5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 32'h00C00141, 1'b0, 256'h12345678);
        vecs[4]  = mk(1'b0, 64'h100, 3'd3, 8'd0, 256'd0,        5'h04, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00C00061, 1'b1, 256'hDEADBEEF);
        vecs[5]  = mk(1'b1, 64'h300, 3'd0, 8'd7, 256'hA5,       5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00C00703, 1'b1, 256'd0);
        vecs[6]  = mk(1'b0, 64'h100, 3'd3, 8'd0, 256'd0,        5'h02, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00C00061, 1'b1, 256'hDEADBEEF);
        vecs[7]  = mk(1'b0, 64'h200, 3'd2, 8'd1, 256'd0,        5'h02, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h00C00141, 1'b1, 256'h12345678);
        vecs[8]  = mk(1'b0, 64'h100, 3'd3, 8'd0, 256'd0,        5'h02, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h00C00061, 1'b1, 256'd0);
        vecs[9]  = mk(1'b0, 64'h200, 3'd2, 8'd1, 256'd0,        5'h02, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h00C00141, 1'b0, 256'd0);
        vecs[10] = mk(1'b0, 64'h100, 3'd3, 8'd0, 256'd0,        5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 32'h00C00061, 1'b0, 256'hDEADBEEF);

        nreset = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 64'd0; cmd_size = 3'd0;
        cmd_len = 8'd0; cmd_data = 256'd0;
        uhost_req_ready = 1'b0; uhost_resp_valid = 1'b0; uhost_resp_cmd = 32'd0;
        uhost_resp_dstaddr = 64'd0; uhost_resp_srcaddr = 64'd0; uhost_resp_data = 256'd0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        nreset = 1'b1;

        for (int i = 0; i <= 8; i++) run_txn(vecs[i]);

        // Late response after the timeout: must be dropped and counted
        tick();
        uhost_resp_valid   = 1'b1;
        uhost_resp_cmd     = {27'd0, 5'h02};
        uhost_resp_dstaddr = SRC;
        uhost_resp_srcaddr = 64'h100;
        uhost_resp_data    = 256'h5555;
        tick();
        uhost_resp_valid = 1'b0;
        chk("stray_cnt", {240'd0, stray_cnt}, 256'd1);
        chk("stray_no_rsp", {255'd0, rsp_valid}, 256'd0);
        chk("stray_cmd_ready", {255'd0, cmd_ready}, 256'd1);

        run_txn(vecs[9]);
        run_txn(vecs[10]);

        repeat (2) tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
